dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters:
  - port 0: LSU memory side;
  - port 1: secondary master, e.g. debug/DMA loader.
- Latches one request, drives the memory handshake until memory acknowledges or a watchdog expires, then returns read data and releases the winner's stall for exactly one cycle.
- Sits between LSU/secondary master and the data RAM wrapper.

---
 rtl/dmem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: latches one request, runs the memory handshake
// with a watchdog, then releases the winner for one cycle. Optional: DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_stall,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_stall,
    output logic        m1_err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               win;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic               last_q, last_d;

    // On a tie the port that was not served last wins.
    assign win = (m0_req && m1_req) ? ~last_q : m1_req;
`else
    assign win = m1_req & ~m0_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d     = win;
                    mem_req_d   = 1'b1;
                    mem_we_d    = win ? m1_we    : m0_we;
                    mem_be_d    = win ? m1_be    : m0_be;
                    mem_addr_d  = win ? m1_addr  : m0_addr;
                    mem_wdata_d = win ? m1_wdata : m0_wdata;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Ready is tested first so an ack in the expiry cycle completes normally.
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                last_d  = owner_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    logic resp0, resp1;

    assign resp0 = (state_q == RESP) && (owner_q == 1'b0);
    assign resp1 = (state_q == RESP) && (owner_q == 1'b1);

    assign m0_stall = m0_req & ~resp0;
    assign m1_stall = m1_req & ~resp1;
    assign m0_rdata = resp0 ? rdata_q : '0;
    assign m1_rdata = resp1 ? rdata_q : '0;
    assign m0_err   = resp0 & err_q;
    assign m1_err   = resp1 & err_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; inputs change just after the
// rising edge, outputs are sampled on the falling edge.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be, mem_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_stall, m0_err, m1_stall, m1_err;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks;
    int n_errors;

    dmem_arbiter #(
        .TIMEOUT(16),
        .CNT_W  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_be    (m0_be),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_stall (m0_stall),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_be    (m1_be),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_stall (m1_stall),
        .m1_err   (m1_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int n;
    logic [1:0] exp_grant [4];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        m0_req = 0; m0_we = 0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_grant[0] = 0; exp_grant[1] = 1; exp_grant[2] = 0; exp_grant[3] = 1;
`else
        exp_grant[0] = 0; exp_grant[1] = 0; exp_grant[2] = 0; exp_grant[3] = 0;
`endif

        // reset state
        repeat (2) smp();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        go(); reset = 1'b1;

        // single read, memory acks in first mem_req cycle
        go(); m0_req = 1; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h100;
        smp(); check("rd_stall_raise", {31'd0, m0_stall}, 32'd1);
        check("rd_memreq_idle", {31'd0, mem_req}, 32'd0);
        go(); mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        smp(); check("rd_memreq", {31'd0, mem_req}, 32'd1);
        check("rd_addr", mem_addr, 32'h100);
        check("rd_we", {31'd0, mem_we}, 32'd0);
        go(); mem_ready = 0; mem_rdata = '0;
        smp(); check("rd_release", {31'd0, m0_stall}, 32'd0);
        check("rd_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_err", {31'd0, m0_err}, 32'd0);
        check("rd_memreq_drop", {31'd0, mem_req}, 32'd0);
        go(); m0_req = 0;
        smp(); check("rd_idle_memreq", {31'd0, mem_req}, 32'd0);

        // write pass-through on port 1, ack in third mem_req cycle
        go(); m1_req = 1; m1_we = 1; m1_be = 4'b1100; m1_addr = 32'h204; m1_wdata = 32'hABCDABCD;
        smp(); check("wr_stall_raise", {31'd0, m1_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            go();
            if (i == 2) mem_ready = 1;
            smp();
            check("wr_memreq", {31'd0, mem_req}, 32'd1);
            check("wr_we", {31'd0, mem_we}, 32'd1);
            check("wr_be", {28'd0, mem_be}, 32'h0000000C);
            check("wr_addr", mem_addr, 32'h204);
            check("wr_wdata", mem_wdata, 32'hABCDABCD);
            check("wr_stall_hold", {31'd0, m1_stall}, 32'd1);
        end
        go(); mem_ready = 0;
        smp(); check("wr_release", {31'd0, m1_stall}, 32'd0);
        check("wr_err", {31'd0, m1_err}, 32'd0);
        check("wr_m0_rdata", m0_rdata, 32'd0);
        go(); m1_req = 0; m1_we = 0;

        // tie with continuous requests from both ports
        go(); m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            go(); mem_ready = 1; mem_rdata = 32'h1000 + i;
            smp(); check("tie_addr", mem_addr, exp_grant[i] == 1 ? 32'h20 : 32'h10);
            go(); mem_ready = 0;
            smp();
            check("tie_m0_stall", {31'd0, m0_stall}, exp_grant[i] == 0 ? 32'd0 : 32'd1);
            check("tie_m1_stall", {31'd0, m1_stall}, exp_grant[i] == 1 ? 32'd0 : 32'd1);
            check("tie_m0_rdata", m0_rdata, exp_grant[i] == 0 ? 32'h1000 + i : 32'd0);
            check("tie_m1_rdata", m1_rdata, exp_grant[i] == 1 ? 32'h1000 + i : 32'd0);
            go();
            if (i == 3) begin
                m0_req = 0; m1_req = 0;
            end
        end
        go();
        smp(); check("tie_done_memreq", {31'd0, mem_req}, 32'd0);

        // watchdog expiry
        go(); m0_req = 1; m0_we = 0; m0_addr = 32'h300;
        go();
        smp();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            go();
            smp();
        end
        check("tmo_memreq_cycles", n, 32'd16);
        check("tmo_release", {31'd0, m0_stall}, 32'd0);
        check("tmo_rdata", m0_rdata, 32'd0);
        check("tmo_err", {31'd0, m0_err}, 32'd1);
        go(); m0_addr = 32'h304;
        smp(); check("tmo_err_pulse", {31'd0, m0_err}, 32'd0);
        go(); mem_ready = 1; mem_rdata = 32'h55AA55AA;
        smp(); check("post_tmo_addr", mem_addr, 32'h304);
        go(); mem_ready = 0;
        smp(); check("post_tmo_rdata", m0_rdata, 32'h55AA55AA);
        check("post_tmo_err", {31'd0, m0_err}, 32'd0);
        go(); m0_req = 0;

        // ack in the expiry cycle
        go(); m0_req = 1; m0_addr = 32'h308;
        go();
        repeat (15) go();
        mem_ready = 1; mem_rdata = 32'h12345678;
        smp(); check("bnd_memreq", {31'd0, mem_req}, 32'd1);
        go(); mem_ready = 0;
        smp(); check("bnd_release", {31'd0, m0_stall}, 32'd0);
        check("bnd_rdata", m0_rdata, 32'h12345678);
        check("bnd_err", {31'd0, m0_err}, 32'd0);
        go(); m0_req = 0;

        // asynchronous reset during an access
        go(); m1_req = 1; m1_we = 0; m1_addr = 32'h400;
        go();
        smp(); check("rstm_memreq_pre", {31'd0, mem_req}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("rstm_memreq_async", {31'd0, mem_req}, 32'd0);
        check("rstm_stall", {31'd0, m1_stall}, 32'd1);
        check("rstm_err", {31'd0, m1_err}, 32'd0);
        go();
        smp(); check("rstm_memreq_held", {31'd0, mem_req}, 32'd0);
        go(); reset = 1'b1; m1_addr = 32'h404;
        smp(); check("rstm_new_stall", {31'd0, m1_stall}, 32'd1);
        go(); mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        smp(); check("rstm_new_addr", mem_addr, 32'h404);
        go(); mem_ready = 0;
        smp(); check("rstm_new_release", {31'd0, m1_stall}, 32'd0);
        check("rstm_new_rdata", m1_rdata, 32'hCAFEF00D);
        check("rstm_new_err", {31'd0, m1_err}, 32'd0);
        go(); m1_req = 0;
        smp();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
